// File: rtl/sum_uart_pkg.sv
// sum_uart_pkg: shared state encoding and frame constants for the sum UART transmitter
package sum_uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
endpackage

// File: rtl/sum_fifo.sv
// sum_fifo: synchronous FIFO with combinational head and registered occupancy
module sum_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    assign rd_data = mem_q[rd_ptr_q];
    assign level = level_q;
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d = level_q + LW'(push) - LW'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q <= level_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/sum_uart_tx.sv
// sum_uart_tx: buffers sum bytes and sends each as an 8N1 UART frame, LSB first
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, head;
    logic tx_q, tx_d, busy_q, busy_d;
    logic push, pop, last, frame_end;
    assign in_ready = !rst && level < LW'(FIFO_DEPTH);
    assign push = in_valid && in_ready;
    assign last = cnt_q == CNT_MAX;
    assign frame_end = state_q == STOP && last && idx_q == IW'(STOP_BITS - 1);
    // Popping from STOP on its final cycle chains frames with no idle gap
    assign pop = level != '0 && (state_q == IDLE || frame_end);
    assign tx = tx_q;
    assign busy = busy_q;
    sum_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .wr_data(in_data),
        .rd_data(head),
        .level(level)
    );
    always_comb begin
        state_d = state_q;
        cnt_d = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        shift_d = shift_q;
        tx_d = tx_q;
        busy_d = busy_q;
        if (pop) begin
            state_d = START;
            shift_d = head;
            tx_d = 1'b0;
            busy_d = 1'b1;
        end else if (last) begin
            unique case (state_q)
                START: begin
                    state_d = DATA;
                    idx_d = '0;
                    tx_d = shift_q[0];
                end
                DATA: begin
                    state_d = idx_q == IW'(DATA_BITS - 1) ? STOP : DATA;
                    idx_d = idx_q == IW'(DATA_BITS - 1) ? '0 : idx_q + 1'b1;
                    shift_d = shift_q >> 1;
                    tx_d = idx_q == IW'(DATA_BITS - 1) ? 1'b1 : shift_q[1];
                end
                STOP: begin
                    state_d = frame_end ? IDLE : STOP;
                    idx_d = frame_end ? '0 : idx_q + 1'b1;
                    busy_d = !frame_end;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            idx_q <= '0;
            shift_q <= '0;
            tx_q <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            shift_q <= shift_d;
            tx_q <= tx_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: tb/tb_sum_uart_tx.sv
// tb_sum_uart_tx: scoreboard bench decoding the serial line against queued bytes
module tb_sum_uart_tx;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_ready, tx, busy;
    logic [2:0] level;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int base = 0;
    logic [7:0] sb_q[$];
    bit mon_active = 0;
    int mon_cnt = 0;
    logic [7:0] mon_byte = '0;
    int frames = 0;
    int last_start = 0;
    int last_gap = 0;
    int max_level = 0;

    sum_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx(tx),
        .busy(busy),
        .level(level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Line monitor: counts negedges from the first low sample of a start bit
    always @(negedge clk) begin
        if (32'(level) > max_level) max_level = 32'(level);
        if (rst) begin
            mon_active = 0;
        end else if (!mon_active) begin
            if (!tx) begin
                mon_active = 1;
                mon_cnt = 0;
                last_gap = cyc - last_start;
                last_start = cyc;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 2) chk("start_bit", tx, 0);
            else if (mon_cnt >= 6 && mon_cnt <= 34 && mon_cnt % 4 == 2) mon_byte[(mon_cnt - 6) / 4] = tx;
            else if (mon_cnt == 38) begin
                chk("stop_bit", tx, 1);
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) chk("rx_byte", mon_byte, sb_q.pop_front());
                frames++;
            end else if (mon_cnt == 39) mon_active = 0;
        end
    end

    task automatic at(input int i);
        while (cyc < base + i + 1) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, output int e);
        bit ok = 0;
        in_data = b;
        in_valid = 1'b1;
        e = -1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                sb_q.push_back(b);
                e = cyc - base;
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("accept", ok, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb_q.size() == 0 && !mon_active && !busy) break;
            @(negedge clk);
        end
        chk("drain", sb_q.size() == 0 && !mon_active && !busy, 1);
    endtask

    initial begin
        int e, f0, lows;
        int acc[6];
        logic [9:0] frame;
        logic [7:0] fill[6];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33;
        fill[3] = 8'h44; fill[4] = 8'h55; fill[5] = 8'h66;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", in_ready, 1);

        // Single byte: exact per-cycle line and busy timeline
        base = cyc;
        send(8'hA5, e);
        chk("single_edge", e, 0);
        chk("single_lvl0", level, 1);
        chk("single_busy0", busy, 0);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 1; i <= 40; i++) begin
            at(i);
            chk("single_tx", tx, frame[(i - 1) / 4]);
            chk("single_busy", busy, 1);
        end
        at(41);
        chk("single_tx_end", tx, 1);
        chk("single_busy_end", busy, 0);
        chk("single_lvl_end", level, 0);
        wait_idle(100);

        // Back-to-back: 0x00 then 0xFF with no idle cycle between frames
        repeat (3) @(negedge clk);
        f0 = frames;
        base = cyc;
        send(8'h00, e);
        send(8'hFF, e);
        chk("b2b_edge2", e, 1);
        lows = 0;
        for (int i = 1; i <= 80; i++) begin
            at(i);
            if (!busy) lows++;
        end
        chk("b2b_busy_gaps", lows, 0);
        at(81);
        chk("b2b_busy_end", busy, 0);
        wait_idle(100);
        chk("b2b_frames", frames - f0, 2);
        chk("b2b_gap", last_gap, 40);

        // Fill and backpressure with a simultaneous pop while full
        repeat (3) @(negedge clk);
        f0 = frames;
        max_level = 0;
        base = cyc;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send(fill[k], e);
                    acc[k] = e;
                end
            end
            begin
                at(4);
                chk("fill_lvl4", level, 4);
                chk("fill_ready4", in_ready, 0);
                at(40);
                chk("fill_lvl40", level, 4);
                chk("fill_ready40", in_ready, 0);
                at(41);
                chk("fill_lvl41", level, 3);
                chk("fill_ready41", in_ready, 1);
                at(42);
                chk("fill_lvl42", level, 4);
            end
        join
        for (int k = 0; k < 5; k++) chk("fill_acc", acc[k], k);
        chk("fill_acc6", acc[5], 42);
        wait_idle(400);
        chk("fill_frames", frames - f0, 6);
        chk("fill_max_level", max_level, 4);

        // Reset during data bit 3 with two bytes still queued
        repeat (3) @(negedge clk);
        f0 = frames;
        base = cyc;
        send(8'h5A, e);
        send(8'hC3, e);
        send(8'h96, e);
        at(18);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_lvl", level, 2);
        rst = 1'b1;
        sb_q.delete();
        at(19);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_lvl", level, 0);
        in_data = 8'h3C;
        in_valid = 1'b1;
        chk("rst_in_ready", in_ready, 0);
        at(21);
        chk("rst_in_lvl", level, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!tx || busy) lows++;
        end
        chk("post_rst_quiet", lows, 0);
        chk("post_rst_lvl", level, 0);
        chk("post_rst_frames", frames - f0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
